// File: rtl/regfile_arbiter_pkg.sv
// Shared types and constants for the register-file sequencer/arbiter.
// Defines the INIT/RUN state encoding and default widths.
package regfile_arbiter_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NUM_REGS            = 4;
  localparam int NUM_REQ             = 2;
  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_INDEX_WIDTH     = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, ties go to the input not granted last.
// Pointer moves only when advance is high and something was granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Clears the register file after reset, then grants one access per cycle round-robin.
// Read data returns one cycle after acceptance; responses cannot be backpressured.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*INDEX_WIDTH-1:0] req_index,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           busy,
  output logic [INDEX_WIDTH-1:0]         rf_read_index,
  input  logic [DATA_WIDTH-1:0]          rf_read_data,
  output logic [INDEX_WIDTH-1:0]         rf_write_index,
  output logic                           rf_write_enable,
  output logic [DATA_WIDTH-1:0]          rf_write_data
);

  state_t                 state, state_next;
  logic [INDEX_WIDTH-1:0] clr_cnt, clr_cnt_next;
  logic                   run;
  logic [NUM_REQ-1:0]     arb_req;
  logic [NUM_REQ-1:0]     grant;
  logic                   gnt_any, gnt_write, gnt_read;
  logic [INDEX_WIDTH-1:0] gnt_index;
  logic [DATA_WIDTH-1:0]  gnt_wdata;

  assign run     = (state == RUN);
  assign arb_req = run ? req_valid : '0;
  assign busy    = ~run;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (arb_req),
    .advance (run),
    .grant   (grant)
  );

  assign gnt_any   = |grant;
  assign gnt_index = grant[1] ? req_index[2*INDEX_WIDTH-1:INDEX_WIDTH] : req_index[INDEX_WIDTH-1:0];
  assign gnt_wdata = grant[1] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign gnt_write = gnt_any & (grant[1] ? req_write[1] : req_write[0]);
  assign gnt_read  = gnt_any & ~gnt_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    if (state == INIT) begin
      clr_cnt_next = clr_cnt + 1'b1;
      if (clr_cnt == INDEX_WIDTH'(NUM_REGS - 1)) begin
        state_next = RUN;
      end
    end
  end

  // Gated by reset_n so the clear write is not presented while reset is held.
  always_comb begin
    req_ready       = '0;
    rf_read_index   = '0;
    rf_write_enable = 1'b0;
    rf_write_index  = '0;
    rf_write_data   = '0;
    if (reset_n) begin
      if (!run) begin
        rf_write_enable = 1'b1;
        rf_write_index  = clr_cnt;
        rf_write_data   = INIT_VALUE;
      end else begin
        req_ready = grant;
        if (gnt_read) begin
          rf_read_index = gnt_index;
        end
        if (gnt_write) begin
          rf_write_enable = 1'b1;
          rf_write_index  = gnt_index;
          rf_write_data   = gnt_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= gnt_read ? grant : '0;
      if (gnt_read) begin
        rsp_rdata <= rf_read_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter with a behavioural 4x16 register file and a read scoreboard.
module tb_regfile_arbiter;

  localparam int DW = 16;
  localparam int IW = 2;

  logic           clk;
  logic           reset_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [1:0]     req_write;
  logic [2*IW-1:0] req_index;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]     rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           busy;
  logic [IW-1:0]  rf_read_index;
  logic [DW-1:0]  rf_read_data;
  logic [IW-1:0]  rf_write_index;
  logic           rf_write_enable;
  logic [DW-1:0]  rf_write_data;

  regfile_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_index       (req_index),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .busy            (busy),
    .rf_read_index   (rf_read_index),
    .rf_read_data    (rf_read_data),
    .rf_write_index  (rf_write_index),
    .rf_write_enable (rf_write_enable),
    .rf_write_data   (rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file starts with junk so the clear sequence is observable.
  logic [DW-1:0] rf_mem [4] = '{16'hA5A5, 16'h5A5A, 16'hC3C3, 16'h3C3C};
  assign rf_read_data = rf_mem[rf_read_index];
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_index] <= rf_write_data;

  typedef struct {
    int            who;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  exp_t          sb[$];
  int            glog[$];
  logic [DW-1:0] shadow [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks responses against the scoreboard and records accepts for the coming edge.
  always @(negedge clk) begin : monitor
    exp_t          e;
    logic [1:0]    ev;
    int            w;
    logic [IW-1:0] idx;
    logic [DW-1:0] wd;
    if (reset_n === 1'b1) begin
      if (rsp_valid !== 2'b00) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: rsp_valid=%b while no read outstanding", rsp_valid);
        end else begin
          e  = sb.pop_front();
          ev = 2'b01 << e.who;
          if (rsp_valid !== ev || rsp_rdata !== e.data || cyc != e.due) begin
            bad++;
            $display("FAIL rsp_check: got valid=%b data=%h cyc=%0d, want valid=%b data=%h cyc=%0d",
                     rsp_valid, rsp_rdata, cyc, ev, e.data, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        total++;
        bad++;
        e = sb.pop_front();
        $display("FAIL rsp_missing: no rsp_valid at cyc=%0d, want requester %0d data=%h", cyc, e.who, e.data);
      end
      if (busy === 1'b0) begin
        total++;
        if ((req_ready & ~req_valid) != 2'b00 || req_ready == 2'b11 ||
            (req_valid != 2'b00 && req_ready == 2'b00)) begin
          bad++;
          $display("FAIL ready_legal: req_ready=%b with req_valid=%b", req_ready, req_valid);
        end
        if (req_ready != 2'b00) begin
          w   = req_ready[1] ? 1 : 0;
          idx = req_index[w*IW +: IW];
          wd  = req_wdata[w*DW +: DW];
          glog.push_back(w);
          if (req_write[w]) begin
            total++;
            if (rf_write_enable !== 1'b1 || rf_write_index !== idx || rf_write_data !== wd) begin
              bad++;
              $display("FAIL grant_write: we=%b idx=%0d data=%h, want we=1 idx=%0d data=%h",
                       rf_write_enable, rf_write_index, rf_write_data, idx, wd);
            end
            shadow[idx] = wd;
          end else begin
            sb.push_back('{who: w, data: shadow[idx], due: cyc + 1});
          end
        end else begin
          total++;
          if (rf_write_enable !== 1'b0) begin
            bad++;
            $display("FAIL idle_write: rf_write_enable=%b, want 0 when nothing granted", rf_write_enable);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_and_wait();
    bit ok = 0;
    reset_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL clear_timeout: busy=%b, want 0 within 10 cycles", busy);
    end
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    for (int i = 0; i < 4; i++) shadow[i] = 16'h0000;
    sb.delete();
    glog.delete();
    release_and_wait();
  endtask

  task automatic do_req(input int r, input bit wr, input int idx, input logic [DW-1:0] data);
    bit ok = 0;
    req_write[r]         = wr;
    req_index[r*IW +: IW] = IW'(idx);
    req_wdata[r*DW +: DW] = data;
    req_valid[r]         = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: requester %0d never got req_ready, want accept within 20 cycles", r);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_index = '0;
    req_wdata = '0;
    for (int i = 0; i < 4; i++) shadow[i] = 16'h0000;
    tick();
    tick();
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, busy, rf_write_enable, rf_write_index, rf_write_data, rf_read_index}
        !== {2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 2'b00}) begin
      bad++;
      $display("FAIL reset_values: ready=%b rsp_v=%b rdata=%h busy=%b we=%b widx=%0d wdata=%h ridx=%0d, want 0/0/0/1/0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, busy, rf_write_enable, rf_write_index, rf_write_data, rf_read_index);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (rf_write_enable !== 1'b1 || rf_write_index !== IW'(k) || rf_write_data !== 16'h0000 ||
          busy !== 1'b1 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL clear_step%0d: we=%b idx=%0d data=%h busy=%b ready=%b, want 1/%0d/0000/1/00",
                 k, rf_write_enable, rf_write_index, rf_write_data, busy, req_ready, k);
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || req_ready !== 2'b01) begin
      bad++;
      $display("FAIL first_run_cycle: busy=%b ready=%b, want busy=0 ready=01", busy, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    drain();
    for (int i = 0; i < 4; i++) do_req(0, 1'b0, i, 16'h0000);
    drain();
  endtask

  task automatic test_contention();
    apply_reset();
    req_write = 2'b00;
    req_index = {2'd1, 2'd1};
    req_valid = 2'b11;
    repeat (6) tick();
    req_valid = 2'b00;
    drain();
    total++;
    if (glog.size() != 6) begin
      bad++;
      $display("FAIL contention_count: %0d grants, want 6", glog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (glog[i] != (i % 2)) begin
          bad++;
          $display("FAIL contention_order[%0d]: granted %0d, want %0d", i, glog[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_single();
    do_req(0, 1'b1, 2, 16'hBEEF);
    do_req(0, 1'b0, 2, 16'h0000);
    drain();
    total++;
    if (rsp_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL idle_hold: rsp_rdata=%h, want beef held", rsp_rdata);
    end
  endtask

  task automatic test_mixed();
    logic [1:0] rdy;
    do_req(1, 1'b0, 0, 16'h0000);
    drain();
    glog.delete();
    req_write = 2'b01;
    req_index = {2'd3, 2'd3};
    req_wdata = {16'h0000, 16'h1234};
    req_valid = 2'b11;
    for (int n = 0; n < 20 && req_valid != 2'b00; n++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~rdy;
    end
    total++;
    if (req_valid != 2'b00) begin
      bad++;
      $display("FAIL mixed_timeout: req_valid=%b still pending, want 00", req_valid);
      req_valid = 2'b00;
    end
    drain();
    total++;
    if (glog.size() != 2 || glog[0] != 0 || glog[1] != 1) begin
      bad++;
      $display("FAIL mixed_order: %0d grants first=%0d, want 2 grants 0 then 1",
               glog.size(), (glog.size() > 0) ? glog[0] : -1);
    end
    total++;
    if (rsp_rdata !== 16'h1234) begin
      bad++;
      $display("FAIL mixed_data: rsp_rdata=%h, want 1234", rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_req(i % 2, 1'b1, i, DW'(16'h1100 + i * 16'h0101));
    for (int i = 0; i < 4; i++) do_req((i + 1) % 2, 1'b0, i, 16'h0000);
    drain();
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    req_write[0] = 1'b0;
    req_index[IW-1:0] = 2'd2;
    req_valid[0] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        ok = 1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mid_accept_timeout: read never accepted, want accept within 20 cycles");
    end
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    req_valid = 2'b00;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, busy, rf_write_enable, rf_write_index, rf_write_data, rf_read_index}
        !== {2'b00, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 2'b00}) begin
      bad++;
      $display("FAIL mid_reset_values: ready=%b rsp_v=%b rdata=%h busy=%b we=%b widx=%0d wdata=%h ridx=%0d, want 0/0/0/1/0/0/0/0",
               req_ready, rsp_valid, rsp_rdata, busy, rf_write_enable, rf_write_index, rf_write_data, rf_read_index);
    end
    sb.delete();
    @(negedge clk);
    total++;
    if (rsp_valid !== 2'b00) begin
      bad++;
      $display("FAIL mid_dropped: rsp_valid=%b during reset, want 00", rsp_valid);
    end
    tick();
    for (int i = 0; i < 4; i++) shadow[i] = 16'h0000;
    release_and_wait();
    do_req(0, 1'b0, 2, 16'h0000);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_mixed();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Sequencer and arbiter sitting in front of the 4-entry x 16-bit register file (one combinational read port, one clocked write port). After reset it clears all four registers through the write port, then shares the single access slot per cycle between two requesters using round-robin arbitration with a valid/ready handshake. Read data returns one cycle after acceptance on a registered response port.

## Interface
Parameters:
- DATA_WIDTH, 16, register width
- INDEX_WIDTH, 2, register index width (4 registers)
- INIT_VALUE, 16'h0000, value written to every register during the clear sequence

Ports (requester i = 0,1; per-requester fields packed, requester 1 in the upper slice):
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  request present
- req_ready  out  2  request accepted this cycle when valid & ready
- req_write  in  2  1 = write, 0 = read
- req_index  in  2*INDEX_WIDTH  target register
- req_wdata  in  2*DATA_WIDTH  write data
- rsp_valid  out  2  one-cycle pulse, read data valid for requester i
- rsp_rdata  out  DATA_WIDTH  read data (shared, qualified by rsp_valid)
- busy  out  1  high while the clear sequence runs
- rf_read_index  out  INDEX_WIDTH  to register file read index
- rf_read_data  in  DATA_WIDTH  from register file read data (combinational)
- rf_write_index  out  INDEX_WIDTH  to register file write index
- rf_write_enable  out  1  to register file write enable
- rf_write_data  out  DATA_WIDTH  to register file write data

## Operation
- States: INIT, RUN. reset_n low forces INIT with clear counter = 0.
- INIT: each cycle drives rf_write_enable=1, rf_write_index=counter, rf_write_data=INIT_VALUE; counter increments. After index 3 is written, next state RUN. busy=1, req_ready=0 throughout.
- RUN: at most one request granted per cycle (read or write, never both).
  - Only requester 0 valid -> grant 0; only 1 valid -> grant 1.
  - Both valid -> grant the requester not granted most recently; priority pointer updates only on a grant.
  - Pointer reset value: "last granted = 1", so requester 0 wins the first tie.
- req_ready[i] = RUN & grant[i]; combinational from req_valid (no dependency of req_valid on req_ready permitted in requesters).
- Granted write: rf_write_enable=1, rf_write_index/data from granted requester, same cycle.
- Granted read: rf_read_index = granted index; rf_read_data captured into rsp_rdata at the clock edge; rsp_valid[i] pulses the next cycle.
- No response for writes. No backpressure on responses: requester must accept rsp_valid.
- Requester holds valid, write, index, wdata stable until accepted.
- Idle cycles (RUN, no grant): rf_write_enable=0, rsp_rdata holds last value.
- reset_n asserted mid-operation: in-flight response dropped (rsp_valid cleared), pointer reset, clear sequence restarts from index 0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=1, rf_write_enable=0, rf_write_index=0, rf_write_data=0, rf_read_index=0.
- Clear sequence: 4 cycles after reset_n deasserts; first request accepted earliest in cycle 5.
- Read latency: accepted in cycle N -> rsp_valid in cycle N+1, data = register contents during cycle N.
- Read-after-write: write accepted N, read of same index accepted N+1 returns new data.
- Throughput: one access per cycle; back-to-back reads from alternating requesters yield consecutive response pulses.
- With both requesters continuously valid, grants alternate strictly 0,1,0,1...

## Structure
- Package regfile_arbiter_pkg: state enum (INIT, RUN), NUM_REGS=4, NUM_REQ=2, default width constants.
- Sub-module rr_arbiter2: two-input round-robin arbiter (req[1:0], advance, grant[1:0], internal pointer, async active-low reset). Top level holds FSM, clear counter, muxes, response register.

## Test plan
- Reset release: observe 4 INIT writes index 0..3 with INIT_VALUE, busy high 4 cycles, req_ready low; reads of all indices afterwards return 16'h0000.
- Single requester: req 0 writes 16'hBEEF to reg 2, next cycle reads reg 2 -> rsp_valid[0] one cycle later, rsp_rdata=16'hBEEF, rsp_valid[1]=0.
- Contention: both valid continuously reading reg 1 -> grants 0,1,0,1; first tie to requester 0; responses alternate rsp_valid[0], rsp_valid[1].
- Mixed: req 0 writes 16'h1234 to reg 3 while req 1 reads reg 3 -> write granted first, read granted next cycle returns 16'h1234.
- Reset mid-operation: assert reset_n low in the cycle after a read acceptance -> rsp_valid never pulses, outputs return to reset values asynchronously, clear sequence reruns and reg 2 reads 16'h0000.
